pipeline_scoreboard: RTL and testbench

Parametrised hazard scoreboard for the pipelined MIPS core, replacing the fixed load-use hazard check with per-register pending-write tracking. Each ID-stage issue that writes a register records a result latency; the block stalls ID on read-after-write and write-after-write hazards until forwarding can supply the value. It supports multi-cycle execution units and branch resolution in ID. It sits beside the forwarding unit and drives the PC-write, IF/ID-write and control-bubble selects.

---
 rtl/pipeline_scoreboard_if.sv | 35 +++
 rtl/pipeline_scoreboard.sv | 96 +++++++++
 tb/tb_pipeline_scoreboard.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_scoreboard_if.sv
// ID-stage hazard interface: the decode stage presents its instruction and
// receives the stall decision plus observability outputs.
interface pipeline_scoreboard_if #(
    parameter int REG_COUNT = 32,
    parameter int ADDR_W    = 5,
    parameter int LAT_W     = 3
);
    logic              id_valid;
    logic              id_flush;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_branch;
    logic [ADDR_W-1:0] id_rd;
    logic              id_writes;
    logic [LAT_W-1:0]  id_lat;
    logic              stall;
    logic              stall_raw;
    logic              stall_waw;
    logic [REG_COUNT-1:0] busy_vec;
    logic [31:0]       stall_cycles;

    modport master (
        output id_valid, id_flush, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_branch, id_rd, id_writes, id_lat,
        input  stall, stall_raw, stall_waw, busy_vec, stall_cycles
    );

    modport slave (
        input  id_valid, id_flush, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_branch, id_rd, id_writes, id_lat,
        output stall, stall_raw, stall_waw, busy_vec, stall_cycles
    );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Per-register pending-write scoreboard: each register counts down the cycles
// until its in-flight result can be forwarded, and ID stalls on RAW/WAW hazards.
module pipeline_scoreboard #(
    parameter int REG_COUNT    = 32,
    parameter int ADDR_W       = 5,
    parameter int MAX_LAT      = 4,
    parameter int LAT_W        = 3,
    parameter int BRANCH_IN_ID = 1
) (
    input  logic clk,
    input  logic rst,
    pipeline_scoreboard_if.slave sb
);
    localparam logic [LAT_W-1:0] ONE   = LAT_W'(1);
    localparam logic [LAT_W-1:0] MAX_V = LAT_W'(MAX_LAT);
    localparam logic             BR_ID = (BRANCH_IN_ID != 0);

    logic [LAT_W-1:0]     cnt      [REG_COUNT];
    logic [LAT_W-1:0]     cnt_next [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_next;
    logic [31:0]          cycles_q;

    logic             live;
    logic             issue;
    logic             load_en;
    logic             rs_blocked;
    logic             rt_blocked;
    logic             raw;
    logic             waw;
    logic [LAT_W-1:0] cnt_rs;
    logic [LAT_W-1:0] cnt_rt;
    logic [LAT_W-1:0] cnt_rd;
    logic [LAT_W-1:0] lat_load;

    // A count of 1 means the value is forwardable now; branches compared in ID need it fully done.
    always_comb begin
        cnt_rs     = cnt[sb.id_rs];
        cnt_rt     = cnt[sb.id_rt];
        cnt_rd     = cnt[sb.id_rd];
        rs_blocked = 1'b0;
        rt_blocked = 1'b0;
        if (sb.id_uses_rs && (sb.id_rs != '0)) begin
            rs_blocked = (cnt_rs > ONE) || (BR_ID && sb.id_branch && (cnt_rs != '0));
        end
        if (sb.id_uses_rt && (sb.id_rt != '0)) begin
            rt_blocked = (cnt_rt > ONE) || (BR_ID && sb.id_branch && (cnt_rt != '0));
        end
        live     = sb.id_valid & ~sb.id_flush;
        raw      = live & (rs_blocked | rt_blocked);
        waw      = live & sb.id_writes & (sb.id_rd != '0) & (cnt_rd > sb.id_lat);
        issue    = live & ~(raw | waw);
        lat_load = (sb.id_lat > MAX_V) ? MAX_V : sb.id_lat;
        load_en  = issue & sb.id_writes & (sb.id_rd != '0) & (sb.id_lat != '0);
    end

    // An issuing write reloads its target even if that register is still counting.
    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            cnt_next[r]  = '0;
            busy_next[r] = 1'b0;
            if (r != 0) begin
                if (load_en && (sb.id_rd == ADDR_W'(r))) begin
                    cnt_next[r] = lat_load;
                end else if (cnt[r] != '0) begin
                    cnt_next[r] = cnt[r] - ONE;
                end
                busy_next[r] = (cnt_next[r] != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                cnt[r] <= '0;
            end
            busy_q   <= '0;
            cycles_q <= '0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                cnt[r] <= cnt_next[r];
            end
            busy_q <= busy_next;
            if ((raw | waw) && (cycles_q != '1)) begin
                cycles_q <= cycles_q + 32'd1;
            end
        end
    end

    assign sb.stall        = raw | waw;
    assign sb.stall_raw    = raw;
    assign sb.stall_waw    = waw;
    assign sb.busy_vec     = busy_q;
    assign sb.stall_cycles = cycles_q;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Scoreboard bench: two DUTs (branch compare in ID on/off) share one stimulus
// stream; a reference model queues expectations that a negedge monitor checks.
module tb_pipeline_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid, flush, branch, uses_rs, uses_rt, writes;
        logic [4:0] rs, rt, rd;
        logic [2:0] lat;
    } instr_t;

    typedef struct {
        logic        stall0, raw0, waw0, stall1;
        logic [31:0] busy0, cyc0, busy1, cyc1;
    } exp_t;

    instr_t cur;
    exp_t   exp_q[$];

    pipeline_scoreboard_if bus0 ();
    pipeline_scoreboard_if bus1 ();

    assign bus0.id_valid = cur.valid;    assign bus1.id_valid = cur.valid;
    assign bus0.id_flush = cur.flush;    assign bus1.id_flush = cur.flush;
    assign bus0.id_rs = cur.rs;          assign bus1.id_rs = cur.rs;
    assign bus0.id_rt = cur.rt;          assign bus1.id_rt = cur.rt;
    assign bus0.id_uses_rs = cur.uses_rs; assign bus1.id_uses_rs = cur.uses_rs;
    assign bus0.id_uses_rt = cur.uses_rt; assign bus1.id_uses_rt = cur.uses_rt;
    assign bus0.id_branch = cur.branch;  assign bus1.id_branch = cur.branch;
    assign bus0.id_rd = cur.rd;          assign bus1.id_rd = cur.rd;
    assign bus0.id_writes = cur.writes;  assign bus1.id_writes = cur.writes;
    assign bus0.id_lat = cur.lat;        assign bus1.id_lat = cur.lat;

    pipeline_scoreboard #(.BRANCH_IN_ID(1)) dut0 (.clk(clk), .rst(rst), .sb(bus0));
    pipeline_scoreboard #(.BRANCH_IN_ID(0)) dut1 (.clk(clk), .rst(rst), .sb(bus1));

    int          checks = 0;
    int          passes = 0;
    int          seen_stall0 = 0;
    int          seen_stall1 = 0;
    int          seen_waw0 = 0;
    int          mcnt [2][32];
    int unsigned mcyc [2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // Model: mcnt = cycles until the pending result is architecturally done.
    function automatic void model_eval(input int k, output logic raw, output logic waw);
        logic bid, live, nr;
        bid  = (k == 0);
        live = cur.valid && !cur.flush;
        nr   = 1'b0;
        if (cur.uses_rs && cur.rs != 0)
            if (mcnt[k][cur.rs] > 1 || (bid && cur.branch && mcnt[k][cur.rs] > 0)) nr = 1'b1;
        if (cur.uses_rt && cur.rt != 0)
            if (mcnt[k][cur.rt] > 1 || (bid && cur.branch && mcnt[k][cur.rt] > 0)) nr = 1'b1;
        raw = live && nr;
        waw = live && cur.writes && cur.rd != 0 && mcnt[k][cur.rd] > int'(cur.lat);
    endfunction

    function automatic logic [31:0] model_busy(input int k);
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = (mcnt[k][r] != 0);
        return b;
    endfunction

    function automatic void model_step(input int k, input logic stall_now, input logic rst_now);
        if (rst_now) begin
            for (int r = 0; r < 32; r++) mcnt[k][r] = 0;
            mcyc[k] = 0;
            return;
        end
        if (stall_now && mcyc[k] != 32'hFFFF_FFFF) mcyc[k]++;
        for (int r = 1; r < 32; r++) if (mcnt[k][r] > 0) mcnt[k][r]--;
        if (cur.valid && !cur.flush && !stall_now && cur.writes && cur.rd != 0 && cur.lat != 0)
            mcnt[k][cur.rd] = int'(cur.lat);
    endfunction

    task automatic applyStimulus(input instr_t in, input logic rst_in, output logic stall0);
        exp_t e;
        logic r0, w0, r1, w1;
        cur = in;
        rst = rst_in;
        model_eval(0, r0, w0);
        model_eval(1, r1, w1);
        e.stall0 = r0 | w0; e.raw0 = r0; e.waw0 = w0; e.stall1 = r1 | w1;
        e.busy0 = model_busy(0); e.cyc0 = mcyc[0];
        e.busy1 = model_busy(1); e.cyc1 = mcyc[1];
        exp_q.push_back(e);
        model_step(0, r0 | w0, rst_in);
        model_step(1, r1 | w1, rst_in);
        stall0 = r0 | w0;
        @(posedge clk);
        #1;
    endtask

    function automatic instr_t nop();
        instr_t i;
        i = '{default: '0};
        return i;
    endfunction

    function automatic instr_t mk(input logic ur, input logic [4:0] rs, input logic ut, input logic [4:0] rt,
                                  input logic wr, input logic [4:0] rd, input logic [2:0] lat, input logic br);
        instr_t i;
        i = '{default: '0};
        i.valid = 1'b1; i.uses_rs = ur; i.rs = rs; i.uses_rt = ut; i.rt = rt;
        i.writes = wr; i.rd = rd; i.lat = lat; i.branch = br;
        return i;
    endfunction

    task automatic idle(input int n);
        logic s;
        for (int i = 0; i < n; i++) applyStimulus(nop(), 1'b0, s);
    endtask

    // Holds an instruction in ID until the reference model says it issues.
    task automatic runInstr(input instr_t in);
        logic s;
        int   n;
        n = 0;
        do begin
            applyStimulus(in, 1'b0, s);
            n++;
        end while (s && n < 20);
        if (s) begin
            checks++;
            $display("[TB] FAIL hold_budget: instruction still stalled after %0d cycles", n);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("stall0", 32'(bus0.stall), 32'(e.stall0));
                checkOutput("stall_raw0", 32'(bus0.stall_raw), 32'(e.raw0));
                checkOutput("stall_waw0", 32'(bus0.stall_waw), 32'(e.waw0));
                checkOutput("busy_vec0", bus0.busy_vec, e.busy0);
                checkOutput("stall_cycles0", bus0.stall_cycles, e.cyc0);
                checkOutput("stall1", 32'(bus1.stall), 32'(e.stall1));
                checkOutput("busy_vec1", bus1.busy_vec, e.busy1);
                checkOutput("stall_cycles1", bus1.stall_cycles, e.cyc1);
                if (bus0.stall) seen_stall0++;
                if (bus1.stall) seen_stall1++;
                if (bus0.stall_waw) seen_waw0++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic   s;
        int     b0, b1;
        instr_t ri;
        cur = nop();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) mcnt[k][r] = 0;
            mcyc[k] = 0;
        end
        @(posedge clk); #1;
        applyStimulus(nop(), 1'b1, s);
        checkOutput("reset_busy", bus0.busy_vec, 32'h0);
        checkOutput("reset_cycles", bus0.stall_cycles, 32'h0);

        b0 = seen_stall0;
        runInstr(mk(0, 0, 0, 0, 1, 5'd8, 3'd2, 0));
        runInstr(mk(1, 5'd8, 0, 0, 1, 5'd10, 3'd1, 0));
        checkOutput("loaduse_stalls", 32'(seen_stall0 - b0), 32'd1);
        checkOutput("loaduse_cycles", bus0.stall_cycles, 32'd1);
        idle(4);

        b0 = seen_stall0;
        runInstr(mk(0, 0, 0, 0, 1, 5'd9, 3'd4, 0));
        runInstr(mk(0, 0, 1, 5'd9, 1, 5'd11, 3'd1, 0));
        checkOutput("mult_stalls", 32'(seen_stall0 - b0), 32'd3);
        checkOutput("mult_busy9_clear", 32'(bus0.busy_vec[9]), 32'd0);
        idle(4);

        b0 = seen_stall0; b1 = seen_stall1;
        runInstr(mk(0, 0, 0, 0, 1, 5'd3, 3'd1, 0));
        runInstr(mk(1, 5'd3, 0, 0, 0, 0, 3'd1, 1));
        checkOutput("branch_id_stalls", 32'(seen_stall0 - b0), 32'd1);
        checkOutput("branch_ex_stalls", 32'(seen_stall1 - b1), 32'd0);
        idle(4);

        b0 = seen_waw0;
        runInstr(mk(0, 0, 0, 0, 1, 5'd5, 3'd4, 0));
        runInstr(mk(0, 0, 0, 0, 1, 5'd5, 3'd1, 0));
        checkOutput("waw_stalls", 32'(seen_waw0 - b0), 32'd3);
        checkOutput("waw_reload_busy", 32'(bus0.busy_vec[5]), 32'd1);
        idle(1);
        checkOutput("waw_reload_done", 32'(bus0.busy_vec[5]), 32'd0);
        idle(4);

        b0 = seen_stall0;
        runInstr(mk(0, 0, 0, 0, 1, 5'd0, 3'd2, 0));
        runInstr(mk(1, 5'd0, 1, 5'd0, 1, 5'd12, 3'd1, 0));
        checkOutput("r0_stalls", 32'(seen_stall0 - b0), 32'd0);
        idle(2);
        checkOutput("r0_busy", bus0.busy_vec, 32'h0);
        b0 = seen_stall0;
        runInstr(mk(0, 0, 0, 0, 1, 5'd8, 3'd2, 0));
        ri = mk(1, 5'd8, 0, 0, 1, 5'd13, 3'd3, 0);
        ri.flush = 1'b1;
        applyStimulus(ri, 1'b0, s);
        checkOutput("flush_stalls", 32'(seen_stall0 - b0), 32'd0);
        checkOutput("flush_no_load", 32'(bus0.busy_vec[13]), 32'd0);
        idle(4);

        runInstr(mk(0, 0, 0, 0, 1, 5'd7, 3'd4, 0));
        idle(1);
        applyStimulus(nop(), 1'b1, s);
        checkOutput("midreset_busy", bus0.busy_vec, 32'h0);
        checkOutput("midreset_cycles", bus0.stall_cycles, 32'h0);
        b0 = seen_stall0;
        runInstr(mk(1, 5'd7, 1, 5'd7, 0, 0, 3'd1, 1));
        checkOutput("midreset_stalls", 32'(seen_stall0 - b0), 32'd0);

        for (int i = 0; i < 400; i++) begin
            ri.valid   = ($urandom % 10) < 8;
            ri.flush   = ($urandom % 10) == 0;
            ri.branch  = ($urandom % 5) == 0;
            ri.uses_rs = 1'($urandom);
            ri.uses_rt = 1'($urandom);
            ri.writes  = ($urandom % 4) != 0;
            ri.rs      = 5'($urandom_range(0, 7));
            ri.rt      = 5'($urandom_range(0, 7));
            ri.rd      = 5'($urandom_range(0, 7));
            ri.lat     = 3'($urandom_range(1, 4));
            applyStimulus(ri, ($urandom % 100) == 0, s);
        end

        idle(2);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
